// File: rtl/intc_vectored.sv
// Vectored fixed-priority interrupt controller: edge capture, mask, in-service stack, vector output.
// Define INTC_NESTING_EN to allow higher-priority channels to preempt one already in service.
module intc_vectored #(
    parameter int               NCH        = 3,
    parameter int               VEC_W      = 12,
    parameter logic [VEC_W-1:0] VEC_BASE   = 12'h000,
    parameter logic [VEC_W-1:0] VEC_STRIDE = 12'h010
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NCH-1:0]                      irq_in,
    input  logic                                int_en,
    input  logic                                mask_we,
    input  logic [NCH-1:0]                      mask_wdata,
    input  logic                                irq_ack,
    input  logic                                irq_eret,
    output logic                                irq_req,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] irq_id,
    output logic [VEC_W-1:0]                    irq_vec,
    output logic [NCH-1:0]                      pending,
    output logic [NCH-1:0]                      in_service
);
    localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] sync1_reg, sync2_reg, hist_reg;
    logic [NCH-1:0] pending_reg, pending_next;
    logic [NCH-1:0] in_service_reg, in_service_next;
    logic [NCH-1:0] mask_reg;

    logic [NCH-1:0] rise, cand, win_oh, is_top_oh, ack_set, eret_clr;
    logic [ID_W-1:0] win_id;
    logic           cand_any, is_any, accept;

    assign rise     = sync2_reg & ~hist_reg;
    assign cand     = pending_reg & ~mask_reg;
    assign cand_any = |cand;
    assign is_any   = |in_service_reg;

    // Highest set index wins; the loop leaves the last (highest) match.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cand[i]) win_id = ID_W'(i);
        end
    end

`ifdef INTC_NESTING_EN
    logic [ID_W-1:0] is_top_id;
    always_comb begin
        is_top_id = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_service_reg[i]) is_top_id = ID_W'(i);
        end
    end
    assign irq_req = int_en & cand_any & (~is_any | (win_id > is_top_id));
`else
    assign irq_req = int_en & cand_any & ~is_any;
`endif

    assign accept  = irq_ack & irq_req;
    assign irq_id  = win_id;
    assign irq_vec = VEC_BASE + VEC_W'(win_id) * VEC_STRIDE;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            if (gi == NCH - 1) begin : g_top
                assign win_oh[gi]    = cand[gi];
                assign is_top_oh[gi] = in_service_reg[gi];
            end else begin : g_low
                assign win_oh[gi]    = cand[gi] & ~(|cand[NCH-1:gi+1]);
                assign is_top_oh[gi] = in_service_reg[gi] & ~(|in_service_reg[NCH-1:gi+1]);
            end
            assign ack_set[gi]  = accept & win_oh[gi];
            assign eret_clr[gi] = irq_eret & is_top_oh[gi];
            // A new edge beats a simultaneous ack, so the request stays latched.
            assign pending_next[gi]    = rise[gi] | (pending_reg[gi] & ~ack_set[gi]);
            assign in_service_next[gi] = ack_set[gi] | (in_service_reg[gi] & ~eret_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg      <= '0;
            sync2_reg      <= '0;
            hist_reg       <= '0;
            pending_reg    <= '0;
            in_service_reg <= '0;
            mask_reg       <= '0;
        end else begin
            sync1_reg      <= irq_in;
            sync2_reg      <= sync1_reg;
            hist_reg       <= sync2_reg;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            if (mask_we) mask_reg <= mask_wdata;
        end
    end

    assign pending    = pending_reg;
    assign in_service = in_service_reg;
endmodule
